// File: rtl/alu_pkg.sv
// Shared definitions for the 16-bit ALU datapath front end.
// Holds the one-hot result-mux select constants, the binary opcode
// constants and the command sequencer FSM state type.
package alu_pkg;

    localparam int unsigned SEL_W = 12;
    localparam int unsigned OP_W  = 4;

    // One-hot select for the ALU result mux
    localparam logic [SEL_W-1:0] OP_AND     = 12'h001;
    localparam logic [SEL_W-1:0] OP_OR      = 12'h002;
    localparam logic [SEL_W-1:0] OP_NOT     = 12'h004;
    localparam logic [SEL_W-1:0] OP_XOR     = 12'h008;
    localparam logic [SEL_W-1:0] OP_NAND    = 12'h010;
    localparam logic [SEL_W-1:0] OP_NOR     = 12'h020;
    localparam logic [SEL_W-1:0] OP_XNOR    = 12'h040;
    localparam logic [SEL_W-1:0] OP_ADD     = 12'h080;
    localparam logic [SEL_W-1:0] OP_SUB     = 12'h100;
    localparam logic [SEL_W-1:0] OP_SHRIGHT = 12'h200;
    localparam logic [SEL_W-1:0] OP_SHLEFT  = 12'h400;
    localparam logic [SEL_W-1:0] OP_CLEAR   = 12'h800;

    // Binary opcodes as carried on the command interface
    localparam logic [OP_W-1:0] OPC_AND     = 4'd0;
    localparam logic [OP_W-1:0] OPC_OR      = 4'd1;
    localparam logic [OP_W-1:0] OPC_NOT     = 4'd2;
    localparam logic [OP_W-1:0] OPC_XOR     = 4'd3;
    localparam logic [OP_W-1:0] OPC_NAND    = 4'd4;
    localparam logic [OP_W-1:0] OPC_NOR     = 4'd5;
    localparam logic [OP_W-1:0] OPC_XNOR    = 4'd6;
    localparam logic [OP_W-1:0] OPC_ADD     = 4'd7;
    localparam logic [OP_W-1:0] OPC_SUB     = 4'd8;
    localparam logic [OP_W-1:0] OPC_SHRIGHT = 4'd9;
    localparam logic [OP_W-1:0] OPC_SHLEFT  = 4'd10;
    localparam logic [OP_W-1:0] OPC_CLEAR   = 4'd11;

    // Command sequencer states
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ISSUE  = 2'd1,
        SETTLE = 2'd2,
        RESP   = 2'd3
    } seq_state_t;

endpackage

// File: rtl/alu_op_decode.sv
// Combinational opcode decoder: 4-bit binary opcode to the 12-bit one-hot
// ALU result-mux select, plus an illegal-opcode flag.
// Ports:
//   op         in  4   binary opcode
//   sel_c      out 12  one-hot select (0 for illegal opcodes)
//   illegal_c  out 1   opcode is outside 0..11
module alu_op_decode
    import alu_pkg::*;
(
    input  logic [OP_W-1:0]  op,
    output logic [SEL_W-1:0] sel_c,
    output logic             illegal_c
);

    always_comb begin
        sel_c     = '0;
        illegal_c = 1'b0;
        case (op)
            OPC_AND:     sel_c = OP_AND;
            OPC_OR:      sel_c = OP_OR;
            OPC_NOT:     sel_c = OP_NOT;
            OPC_XOR:     sel_c = OP_XOR;
            OPC_NAND:    sel_c = OP_NAND;
            OPC_NOR:     sel_c = OP_NOR;
            OPC_XNOR:    sel_c = OP_XNOR;
            OPC_ADD:     sel_c = OP_ADD;
            OPC_SUB:     sel_c = OP_SUB;
            OPC_SHRIGHT: sel_c = OP_SHRIGHT;
            OPC_SHLEFT:  sel_c = OP_SHLEFT;
            OPC_CLEAR:   sel_c = OP_CLEAR;
            default:     illegal_c = 1'b1;
        endcase
    end

endmodule

// File: rtl/alu_op_sequencer.sv
// Command-side front end for the ALU datapath. Accepts one opcode request
// at a time, drives registered operands and the one-hot mux select for two
// cycles, captures the ALU result and returns it over a response handshake.
// Ports:
//   clk, rst_n                 clock, synchronous active-low reset
//   cmd_valid/cmd_ready        request handshake
//   cmd_op, cmd_a, cmd_b       opcode and operands
//   alu_a, alu_b, alu_sel      registered operands and one-hot select to ALU
//   alu_res                    combinational ALU result
//   rsp_valid/rsp_ready        response handshake
//   rsp_data, rsp_zero, rsp_err  captured result, zero flag, illegal-op flag
//   op_count                   completed responses, wrapping
module alu_op_sequencer
    import alu_pkg::*;
#(
    parameter int unsigned W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [OP_W-1:0]  cmd_op,
    input  logic [W-1:0]     cmd_a,
    input  logic [W-1:0]     cmd_b,
    output logic [W-1:0]     alu_a,
    output logic [W-1:0]     alu_b,
    output logic [SEL_W-1:0] alu_sel,
    input  logic [W-1:0]     alu_res,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [W-1:0]     rsp_data,
    output logic             rsp_zero,
    output logic             rsp_err,
    output logic [15:0]      op_count
);

    seq_state_t       state;
    logic [SEL_W-1:0] dec_sel;
    logic             dec_illegal;

    // Decode straight off the command bus so the select is ready on accept
    alu_op_decode u_decode (
        .op        (cmd_op),
        .sel_c     (dec_sel),
        .illegal_c (dec_illegal)
    );

    // Sequencer FSM with all outputs registered alongside the state
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            cmd_ready <= 1'b1;
            alu_sel   <= '0;
            alu_a     <= '0;
            alu_b     <= '0;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            rsp_zero  <= 1'b1;
            rsp_err   <= 1'b0;
            op_count  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        alu_a     <= cmd_a;
                        alu_b     <= cmd_b;
                        cmd_ready <= 1'b0;
                        if (dec_illegal) begin
                            // Skip the ALU entirely and answer with an error
                            rsp_valid <= 1'b1;
                            rsp_data  <= '0;
                            rsp_zero  <= 1'b1;
                            rsp_err   <= 1'b1;
                            state     <= RESP;
                        end else begin
                            alu_sel <= dec_sel;
                            state   <= ISSUE;
                        end
                    end
                end
                ISSUE: begin
                    state <= SETTLE;
                end
                SETTLE: begin
                    rsp_data  <= alu_res;
                    rsp_zero  <= (alu_res == '0);
                    rsp_err   <= 1'b0;
                    rsp_valid <= 1'b1;
                    alu_sel   <= '0;
                    state     <= RESP;
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        cmd_ready <= 1'b1;
                        op_count  <= op_count + 16'd1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
